// File: rtl/dc_tag_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dc_tag_requester_pkg
// Description : Shared data-cache definitions. Holds the requester state
//               encoding, the tag-bank entry field layout (tag, age, state),
//               the entry-state codes and the way-index width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dc_tag_requester_pkg;

    // Way index width (8-way set)
    localparam int WAY_BITS = 3;

    // Tag-bank entry layout: [17:0] tag, [19:18] age, [22:20] state, [23] spare
    localparam int ENTRY_TAG_LSB    = 0;
    localparam int ENTRY_AGE_LSB    = 18;
    localparam int ENTRY_AGE_BITS   = 2;
    localparam int ENTRY_STATE_LSB  = 20;
    localparam int ENTRY_STATE_BITS = 3;

    // Entry state codes written on a fill
    localparam logic [2:0] ENTRY_STATE_LOAD  = 3'b001;
    localparam logic [2:0] ENTRY_STATE_STORE = 3'b010;

    // Requester FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_WAIT_LK = 3'd2;
    localparam logic [2:0] ST_FILL    = 3'd3;
    localparam logic [2:0] ST_WAIT_FL = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    // Entry state to install for a filled line, chosen by the request kind
    function automatic logic [2:0] fill_entry_state(input logic is_store);
        return is_store ? ENTRY_STATE_STORE : ENTRY_STATE_LOAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dc_tag_requester_rr_victim.sv
`default_nettype none
// ============================================================================
// Module      : dc_rr_victim
// Description : Round-robin victim way pointer. Presents the current victim
//               way and advances modulo 8 each time a fill is accepted.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous, active-low
//               advance - a fill write was accepted this cycle
//               ptr     - current victim way (value before the advance)
// Revision    : 1.0 - initial release
// ============================================================================
module dc_rr_victim
    import dc_tag_requester_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    output logic [WAY_BITS-1:0] ptr
);

    logic [WAY_BITS-1:0] r_ptr;

    // Natural 3-bit overflow gives the 7 -> 0 wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= r_ptr + WAY_BITS'(1);
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/dc_tag_requester.sv
`default_nettype none
// ============================================================================
// Module      : dc_tag_requester
// Description : Data-cache tag requester. Accepts a core lookup, queries the
//               tag bank, and on a miss writes a fill entry into the
//               round-robin victim way before answering the core.
// Ports       : clk, reset (sync, active-low)
//               core_req_*  - core lookup request (valid/retry handshake)
//               core_ack_*  - core response (hit, way, fill)
//               tb_req_*    - tag-bank lookup / fill write request
//               tb_ack_*    - tag-bank response (hit, miss, way)
//               miss_cnt    - saturating count of completed misses
// Revision    : 1.0 - initial release
// ============================================================================
module dc_tag_requester
    import dc_tag_requester_pkg::*;
#(
    parameter int Width    = 24,
    parameter int TagBits  = 18,
    parameter int REQ_BITS = 7
) (
    input  logic                clk,
    input  logic                reset,
    // core request
    input  logic                core_req_valid,
    output logic                core_req_retry,
    input  logic [REQ_BITS-1:0] core_req_type,
    input  logic [TagBits-1:0]  core_req_tag,
    // core response
    output logic                core_ack_valid,
    input  logic                core_ack_retry,
    output logic                core_ack_hit,
    output logic [2:0]          core_ack_way,
    output logic                core_ack_fill,
    // tag-bank request
    output logic                tb_req_valid,
    input  logic                tb_req_retry,
    output logic [REQ_BITS-1:0] tb_req_type,
    output logic                tb_write,
    output logic [Width-1:0]    tb_req_tag,
    // tag-bank response
    input  logic                tb_ack_valid,
    output logic                tb_ack_retry,
    input  logic                tb_hit,
    input  logic                tb_miss,
    input  logic [2:0]          tb_way,
    // statistics
    output logic [15:0]         miss_cnt
);

    logic [2:0]          r_state;
    logic [REQ_BITS-1:0] r_type;
    logic [TagBits-1:0]  r_tag;
    logic                r_hit;
    logic                r_fill;
    logic [2:0]          r_way;
    logic [15:0]         r_miss_cnt;

    logic                w_fill_accept;
    logic [WAY_BITS-1:0] w_victim;
    logic [Width-1:0]    w_fill_tag;

    assign w_fill_accept = (r_state == ST_FILL) && !tb_req_retry;

    dc_rr_victim u_victim (
        .clk     (clk),
        .reset   (reset),
        .advance (w_fill_accept),
        .ptr     (w_victim)
    );

    // Fill entry: tag, age cleared, state code from the store bit, spare 0
    always_comb begin
        w_fill_tag = '0;
        w_fill_tag[ENTRY_TAG_LSB +: TagBits] = r_tag;
        w_fill_tag[ENTRY_STATE_LSB +: ENTRY_STATE_BITS] = fill_entry_state(r_type[0]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_type     <= '0;
            r_tag      <= '0;
            r_hit      <= 1'b0;
            r_fill     <= 1'b0;
            r_way      <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (core_req_valid) begin
                        r_type  <= core_req_type;
                        r_tag   <= core_req_tag;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!tb_req_retry) begin
                        r_state <= ST_WAIT_LK;
                    end
                end
                ST_WAIT_LK: begin
                    if (tb_ack_valid) begin
                        r_way <= tb_way;
                        // A response flagging both hit and miss counts as a hit
                        if (tb_hit) begin
                            r_hit   <= 1'b1;
                            r_fill  <= 1'b0;
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (!tb_req_retry) begin
                        r_way   <= w_victim;
                        r_state <= ST_WAIT_FL;
                    end
                end
                ST_WAIT_FL: begin
                    if (tb_ack_valid) begin
                        r_hit   <= 1'b0;
                        r_fill  <= 1'b1;
                        r_state <= ST_RESP;
                        if (r_miss_cnt != 16'hFFFF) begin
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (!core_ack_retry) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_req_retry = (r_state != ST_IDLE);

    assign core_ack_valid = (r_state == ST_RESP);
    assign core_ack_hit   = r_hit;
    assign core_ack_way   = r_way;
    assign core_ack_fill  = r_fill;

    assign tb_req_valid = (r_state == ST_LOOKUP) || (r_state == ST_FILL);
    assign tb_write     = (r_state == ST_FILL);
    assign tb_req_type  = r_type;
    assign tb_req_tag   = (r_state == ST_FILL) ? w_fill_tag : Width'(r_tag);

    assign tb_ack_retry = !((r_state == ST_WAIT_LK) || (r_state == ST_WAIT_FL));

    assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dc_tag_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dc_tag_requester
// Description : Scoreboard bench for dc_tag_requester. Transactions push the
//               expected tag-bank requests and core responses into queues; a
//               negedge monitor pops and compares whenever the DUT transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_tag_requester;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req_valid = 1'b0;
    logic        core_req_retry;
    logic [6:0]  core_req_type = '0;
    logic [17:0] core_req_tag = '0;
    logic        core_ack_valid;
    logic        core_ack_retry = 1'b0;
    logic        core_ack_hit;
    logic [2:0]  core_ack_way;
    logic        core_ack_fill;
    logic        tb_req_valid;
    logic        tb_req_retry = 1'b0;
    logic [6:0]  tb_req_type;
    logic        tb_write;
    logic [23:0] tb_req_tag;
    logic        tb_ack_valid = 1'b0;
    logic        tb_ack_retry;
    logic        tb_hit = 1'b0;
    logic        tb_miss = 1'b0;
    logic [2:0]  tb_way = '0;
    logic [15:0] miss_cnt;

    dc_tag_requester #(.Width(24), .TagBits(18), .REQ_BITS(7)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_retry(core_req_retry),
        .core_req_type(core_req_type), .core_req_tag(core_req_tag),
        .core_ack_valid(core_ack_valid), .core_ack_retry(core_ack_retry),
        .core_ack_hit(core_ack_hit), .core_ack_way(core_ack_way), .core_ack_fill(core_ack_fill),
        .tb_req_valid(tb_req_valid), .tb_req_retry(tb_req_retry), .tb_req_type(tb_req_type),
        .tb_write(tb_write), .tb_req_tag(tb_req_tag),
        .tb_ack_valid(tb_ack_valid), .tb_ack_retry(tb_ack_retry),
        .tb_hit(tb_hit), .tb_miss(tb_miss), .tb_way(tb_way),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    typedef struct {
        logic        hit;
        logic [2:0]  way;
        logic        fill;
        logic [15:0] miss;
        int          lat;
    } core_exp_t;

    typedef struct {
        logic        write;
        logic [6:0]  typ;
        logic [23:0] tag;
    } tb_exp_t;

    core_exp_t core_q[$];
    tb_exp_t   tbreq_q[$];

    logic [2:0]  model_ptr = '0;
    logic [15:0] model_miss = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [23:0] fill_tag(input logic store, input logic [17:0] tag);
        return {1'b0, (store ? 3'b010 : 3'b001), 2'b00, tag};
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        core_hold;
        logic [4:0]  core_prev;
        logic        tbr_hold;
        logic [31:0] tbr_prev;
        logic        seen;
        int          first_cyc;
        core_exp_t   ce;
        tb_exp_t     te;
        core_hold = 1'b0; tbr_hold = 1'b0; seen = 1'b0; first_cyc = 0;
        core_prev = '0; tbr_prev = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                core_hold = 1'b0;
                tbr_hold  = 1'b0;
                seen      = 1'b0;
            end else begin
                // core response side
                if (core_hold && core_ack_valid)
                    check("core_ack_stable", {27'd0, core_ack_hit, core_ack_way, core_ack_fill}, {27'd0, core_prev});
                if (core_ack_valid && !seen) begin
                    seen = 1'b1;
                    first_cyc = cyc;
                    check("core_req_retry_in_resp", {31'd0, core_req_retry}, 32'd1);
                end
                if (core_ack_valid && !core_ack_retry) begin
                    if (core_q.size() == 0) begin
                        timeout("core_ack_unexpected");
                    end else begin
                        ce = core_q.pop_front();
                        check("ack_hit",  {31'd0, core_ack_hit},  {31'd0, ce.hit});
                        check("ack_way",  {29'd0, core_ack_way},  {29'd0, ce.way});
                        check("ack_fill", {31'd0, core_ack_fill}, {31'd0, ce.fill});
                        check("miss_cnt", {16'd0, miss_cnt},      {16'd0, ce.miss});
                        if (ce.lat > 0)
                            check("hit_latency", first_cyc - req_cyc, ce.lat);
                    end
                    seen = 1'b0;
                end
                core_hold = core_ack_valid && core_ack_retry;
                core_prev = {core_ack_hit, core_ack_way, core_ack_fill};

                // tag-bank request side
                if (tbr_hold && tb_req_valid)
                    check("tb_req_stable", {tb_write, tb_req_type, tb_req_tag}, tbr_prev);
                if (tb_req_valid && !tb_req_retry) begin
                    if (tbreq_q.size() == 0) begin
                        timeout("tb_req_unexpected");
                    end else begin
                        te = tbreq_q.pop_front();
                        check("tb_write",    {31'd0, tb_write},    {31'd0, te.write});
                        check("tb_req_type", {25'd0, tb_req_type}, {25'd0, te.typ});
                        check("tb_req_tag",  {8'd0, tb_req_tag},   {8'd0, te.tag});
                    end
                end
                tbr_hold = tb_req_valid && tb_req_retry;
                tbr_prev = {tb_write, tb_req_type, tb_req_tag};
            end
        end
    end

    // ---------------- bounded waits (sampled at negedge) ----------------
    task automatic wait_core_req();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(core_req_valid && !core_req_retry) && n < 40);
        if (core_req_valid && !core_req_retry) req_cyc = cyc;
        else timeout("core_req_wait");
    endtask

    task automatic wait_tb_req(input logic wr);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(tb_req_valid && !tb_req_retry && tb_write == wr) && n < 40);
        if (!(tb_req_valid && !tb_req_retry && tb_write == wr)) timeout("tb_req_wait");
    endtask

    task automatic wait_tb_ack();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(tb_ack_valid && !tb_ack_retry) && n < 40);
        if (!(tb_ack_valid && !tb_ack_retry)) timeout("tb_ack_wait");
    endtask

    task automatic wait_core_ack();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(core_ack_valid && !core_ack_retry) && n < 40);
        if (!(core_ack_valid && !core_ack_retry)) timeout("core_ack_wait");
    endtask

    // ---------------- one full transaction ----------------
    task automatic txn(input logic store, input logic [17:0] tag, input logic hit, input logic miss,
                       input logic [2:0] way, input int lk_retry, input int ack_retry, input int lat);
        core_exp_t  ce;
        tb_exp_t    te;
        logic [6:0] typ;
        typ = store ? 7'h41 : 7'h40;
        te.write = 1'b0; te.typ = typ; te.tag = {6'd0, tag};
        tbreq_q.push_back(te);
        if (hit) begin
            ce.hit = 1'b1; ce.way = way; ce.fill = 1'b0;
        end else begin
            te.write = 1'b1; te.tag = fill_tag(store, tag);
            tbreq_q.push_back(te);
            ce.hit = 1'b0; ce.way = model_ptr; ce.fill = 1'b1;
            model_ptr = model_ptr + 3'd1;
            model_miss = model_miss + 16'd1;
        end
        ce.miss = model_miss; ce.lat = lat;
        core_q.push_back(ce);

        @(posedge clk); #1;
        core_req_valid = 1'b1; core_req_type = typ; core_req_tag = tag;
        wait_core_req();
        @(posedge clk); #1;
        core_req_valid = 1'b0; core_req_tag = '0; core_req_type = '0;
        if (lk_retry > 0) begin
            tb_req_retry = 1'b1;
            repeat (lk_retry) @(posedge clk);
            #1 tb_req_retry = 1'b0;
        end
        wait_tb_req(1'b0);
        @(posedge clk); #1;
        tb_ack_valid = 1'b1; tb_hit = hit; tb_miss = miss; tb_way = way;
        wait_tb_ack();
        @(posedge clk); #1;
        tb_ack_valid = 1'b0; tb_hit = 1'b0; tb_miss = 1'b0; tb_way = '0;
        if (!hit) begin
            wait_tb_req(1'b1);
            @(posedge clk); #1;
            tb_ack_valid = 1'b1; tb_way = 3'd6;   // way on fill ack must be ignored
            wait_tb_ack();
            @(posedge clk); #1;
            tb_ack_valid = 1'b0; tb_way = '0;
        end
        if (ack_retry > 0) begin
            core_ack_retry = 1'b1;
            repeat (ack_retry) @(posedge clk);
            #1 core_ack_retry = 1'b0;
        end
        wait_core_ack();
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        tb_exp_t te;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_core_req_retry", {31'd0, core_req_retry}, 32'd0);
        check("rst_tb_ack_retry",   {31'd0, tb_ack_retry},   32'd1);
        check("rst_core_ack_valid", {31'd0, core_ack_valid}, 32'd0);
        check("rst_tb_req_valid",   {31'd0, tb_req_valid},   32'd0);
        check("rst_miss_cnt",       {16'd0, miss_cnt},       32'd0);

        // store hit, way 5, best-case latency
        txn(1'b1, 18'h2A5A5, 1'b1, 1'b0, 3'd5, 0, 0, 3);
        // load miss -> fill 24'h100011 into way 0
        txn(1'b0, 18'h00011, 1'b0, 1'b1, 3'd2, 0, 0, 0);
        // lookup held under 4 cycles of tag-bank retry
        txn(1'b0, 18'h3FFFF, 1'b1, 1'b0, 3'd2, 4, 0, 0);
        // hit and miss together -> hit, no fill
        txn(1'b1, 18'h15555, 1'b1, 1'b1, 3'd6, 0, 0, 3);

        // reset while waiting for the fill acknowledge
        te.write = 1'b0; te.typ = 7'h40; te.tag = 24'h00ABCD; tbreq_q.push_back(te);
        te.write = 1'b1; te.tag = fill_tag(1'b0, 18'h0ABCD); tbreq_q.push_back(te);
        @(posedge clk); #1;
        core_req_valid = 1'b1; core_req_type = 7'h40; core_req_tag = 18'h0ABCD;
        wait_core_req();
        @(posedge clk); #1 core_req_valid = 1'b0;
        wait_tb_req(1'b0);
        @(posedge clk); #1 tb_ack_valid = 1'b1; tb_miss = 1'b1;
        wait_tb_ack();
        @(posedge clk); #1 tb_ack_valid = 1'b0; tb_miss = 1'b0;
        wait_tb_req(1'b1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        model_ptr = '0; model_miss = '0;
        @(negedge clk);
        check("mid_rst_core_ack_valid", {31'd0, core_ack_valid}, 32'd0);
        check("mid_rst_tb_req_valid",   {31'd0, tb_req_valid},   32'd0);
        check("mid_rst_core_req_retry", {31'd0, core_req_retry}, 32'd0);
        check("mid_rst_tb_ack_retry",   {31'd0, tb_ack_retry},   32'd1);
        check("mid_rst_miss_cnt",       {16'd0, miss_cnt},       32'd0);
        @(posedge clk); #1 tb_ack_valid = 1'b1; tb_miss = 1'b1;
        repeat (2) @(posedge clk);
        #1 tb_ack_valid = 1'b0; tb_miss = 1'b0;
        @(negedge clk);
        check("stray_ack_core_valid", {31'd0, core_ack_valid}, 32'd0);
        check("stray_ack_tb_valid",   {31'd0, tb_req_valid},   32'd0);
        check("stray_ack_miss_cnt",   {16'd0, miss_cnt},       32'd0);

        // nine misses: victim ways 0..7 then 0; last one backpressured on the core side
        for (int i = 0; i < 9; i++)
            txn(i[0], 18'h12340 + 18'(i), 1'b0, 1'b1, 3'd3, 0, (i == 8) ? 3 : 0, 0);

        repeat (3) @(posedge clk);
        check("core_q_drained",  core_q.size(),  0);
        check("tbreq_q_drained", tbreq_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
